// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//
// Fetches 16-bit instruction words from Memory and hands them to the BU2020
// core over a valid/ready handshake. It owns a 12-bit fetch PC, issues
// single-word reads (data returns one cycle later), buffers returned words
// together with their addresses in a small FIFO, and supports redirect (jump)
// with flush.
//
// Parameters
//   RESET_VECTOR    fetch address loaded on reset
//   FIFO_DEPTH      instruction buffer entries (2..8)
//
// Ports
//   clk             single clock, rising edge
//   reset           synchronous, active-high
//   enable          allows new reads to be issued
//   mem_address     read address (fetch PC)
//   mem_read        read strobe, one word per cycle
//   mem_write       always 0
//   mem_data        read data, valid the cycle after the request
//   instruction_bus FIFO head word, 0 when empty
//   instr_valid     FIFO non-empty
//   instr_ready     core accepts head word
//   pc              address of the head word, 0 when empty
//   jump            redirect pulse
//   jump_target     redirect address, sampled with jump
//
// state  | meaning
// -------+---------------------------------------------
// IDLE   | no reads issued; in-flight word lands, FIFO drains
// FETCH  | reads issued whenever buffer space allows
// -----------------------------------------------------------------------------
module instruction_fetch #(
   parameter logic [11:0] RESET_VECTOR = 12'h000,
   parameter int          FIFO_DEPTH   = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   output logic [11:0] mem_address,
   output logic        mem_read,
   output logic        mem_write,
   input  logic [15:0] mem_data,
   output logic [15:0] instruction_bus,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [11:0] pc,
   input  logic        jump,
   input  logic [11:0] jump_target
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
   localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W + 1)'(FIFO_DEPTH);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_FETCH = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [11:0]       fetch_pc_q, fetch_pc_d;
   logic              inflight_q, inflight_d;
   logic [11:0]       inflight_addr_q, inflight_addr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [15:0]       fifo_data_q [FIFO_DEPTH];
   logic [15:0]       fifo_data_d [FIFO_DEPTH];
   logic [11:0]       fifo_addr_q [FIFO_DEPTH];
   logic [11:0]       fifo_addr_d [FIFO_DEPTH];

   logic              pop;
   logic              push;
   logic              issue;
   logic [CNT_W:0]    occupancy;
   logic [CNT_W:0]    limit;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == LAST_PTR) begin
         return '0;
      end
      return p + 1'b1;
   endfunction

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (enable)  state_d = ST_FETCH;
         ST_FETCH: if (!enable) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      instr_valid = (count_q != '0);
      pop         = instr_valid & instr_ready;

      // Space check: words already buffered plus the one returning next cycle,
      // less the one leaving this cycle, must stay below the depth.
      occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
      limit     = DEPTH_C + {{CNT_W{1'b0}}, pop};
      issue     = (state_q == ST_FETCH) && enable && !jump && !reset &&
                  (occupancy < limit);

      // A jump kills the response to the request issued one cycle earlier.
      push = inflight_q && !jump;

      fetch_pc_d = fetch_pc_q;
      if (jump) begin
         fetch_pc_d = jump_target;
      end else if (issue) begin
         fetch_pc_d = fetch_pc_q + 12'd1;
      end

      inflight_d      = issue;
      inflight_addr_d = fetch_pc_q;

      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      count_d     = count_q;
      fifo_data_d = fifo_data_q;
      fifo_addr_d = fifo_addr_q;

      if (jump) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
         end
         if (push) begin
            fifo_data_d[wr_ptr_q] = mem_data;
            fifo_addr_d[wr_ptr_q] = inflight_addr_q;
            wr_ptr_d              = ptr_inc(wr_ptr_q);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= ST_IDLE;
         fetch_pc_q      <= RESET_VECTOR;
         inflight_q      <= 1'b0;
         inflight_addr_q <= 12'h000;
         rd_ptr_q        <= '0;
         wr_ptr_q        <= '0;
         count_q         <= '0;
      end else begin
         state_q         <= state_d;
         fetch_pc_q      <= fetch_pc_d;
         inflight_q      <= inflight_d;
         inflight_addr_q <= inflight_addr_d;
         rd_ptr_q        <= rd_ptr_d;
         wr_ptr_q        <= wr_ptr_d;
         count_q         <= count_d;
      end
   end

   // Buffer storage needs no reset: an entry is only visible once counted.
   always_ff @(posedge clk) begin
      fifo_data_q <= fifo_data_d;
      fifo_addr_q <= fifo_addr_d;
   end

   assign mem_address     = fetch_pc_q;
   assign mem_read        = issue;
   assign mem_write       = 1'b0;
   assign instruction_bus = instr_valid ? fifo_data_q[rd_ptr_q] : 16'h0000;
   assign pc              = instr_valid ? fifo_addr_q[rd_ptr_q] : 12'h000;

endmodule
